// File: rtl/bus_glue.sv
// 68030 bus front-end: address decode into chip selects, wait-state DSACK generation,
// DRAM acknowledge passthrough, boot-ROM overlay, autovectored IACK and bus-error watchdog.
module bus_glue #(
    parameter int unsigned ROM_WAIT    = 3,
    parameter int unsigned IO_WAIT     = 6,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned BOOT_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic [15:0] ADDR,
    input  logic [2:0]  FC,
    input  logic        AS_n,
    input  logic        RW,
    input  logic        DSACK0_DRAM_n,
    input  logic        DSACK1_DRAM_n,
    output logic        CS_DRAM_n,
    output logic        CS_ROM_n,
    output logic        CS_IO_n,
    output logic        DSACK0_n,
    output logic        DSACK1_n,
    output logic        AVEC_n,
    output logic        BERR_n
);

    localparam int unsigned WAIT_W   = $clog2(ROM_WAIT + IO_WAIT + 2);
    localparam int unsigned TMO_W    = $clog2(TIMEOUT + 2);
    localparam int unsigned BOOT_W   = $clog2(BOOT_CYCLES + 2);
    localparam int unsigned ROM_LOAD = (ROM_WAIT > 0) ? ROM_WAIT - 1 : 0;
    localparam int unsigned IO_LOAD  = (IO_WAIT > 0) ? IO_WAIT - 1 : 0;
    localparam int unsigned TMO_LAST = (TIMEOUT > 1) ? TIMEOUT - 1 : 1;

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_WAIT, S_ACK, S_TERM} state_t;
    typedef enum logic [2:0] {D_NONE, D_DRAM, D_ROM, D_IO, D_IACK} dec_t;

    state_t              state, state_nxt;
    dec_t                dec_q, dec_nxt, dec_c, dec_sel;
    logic                as_m, as_s;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    logic [BOOT_W-1:0]   boot_cnt, boot_nxt;
    logic                dram_acked, dram_acked_nxt;
    logic                ack0_q, ack1_q, ack0_nxt, ack1_nxt;
    logic                cs_dram_nxt, cs_rom_nxt, cs_io_nxt, avec_nxt, berr_nxt;
    logic                overlay, zero_wait, dram_ack;

    // Two-flop synchroniser for the asynchronous address strobe
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            as_m <= 1'b1;
            as_s <= 1'b1;
        end else begin
            as_m <= AS_n;
            as_s <= as_m;
        end
    end

    assign overlay   = (boot_cnt < BOOT_W'(BOOT_CYCLES));
    assign dram_ack  = !CS_DRAM_n && (!DSACK0_DRAM_n || !DSACK1_DRAM_n);
    assign zero_wait = (dec_c == D_ROM && ROM_WAIT == 0) || (dec_c == D_IO && IO_WAIT == 0);
    assign dec_sel   = (state == S_DECODE) ? dec_c : dec_q;

    // Address/function-code decode in priority order; ADDR carries A31..A16
    always_comb begin
        dec_c = D_NONE;
        if (FC == 3'd7) begin
            if (ADDR[3:0] == 4'hF) dec_c = D_IACK;
        end else if (ADDR[15:7] == 9'd0) begin
            dec_c = (overlay && RW) ? D_ROM : D_DRAM;
        end else if (ADDR[15:4] == 12'hE00) begin
            dec_c = D_ROM;
        end else if (ADDR[15:4] == 12'hF00) begin
            dec_c = D_IO;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state      <= S_IDLE;
            dec_q      <= D_NONE;
            wait_cnt   <= '0;
            tmo_cnt    <= '0;
            boot_cnt   <= '0;
            dram_acked <= 1'b0;
            ack0_q     <= 1'b1;
            ack1_q     <= 1'b1;
            CS_DRAM_n  <= 1'b1;
            CS_ROM_n   <= 1'b1;
            CS_IO_n    <= 1'b1;
            AVEC_n     <= 1'b1;
            BERR_n     <= 1'b1;
        end else begin
            state      <= state_nxt;
            dec_q      <= dec_nxt;
            wait_cnt   <= wait_nxt;
            tmo_cnt    <= tmo_nxt;
            boot_cnt   <= boot_nxt;
            dram_acked <= dram_acked_nxt;
            ack0_q     <= ack0_nxt;
            ack1_q     <= ack1_nxt;
            CS_DRAM_n  <= cs_dram_nxt;
            CS_ROM_n   <= cs_rom_nxt;
            CS_IO_n    <= cs_io_nxt;
            AVEC_n     <= avec_nxt;
            BERR_n     <= berr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!as_s) state_nxt = S_DECODE;
            S_DECODE: begin
                if (as_s)           state_nxt = S_TERM;
                else if (zero_wait) state_nxt = S_ACK;
                else                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (as_s)
                    state_nxt = S_TERM;
                else if (dec_q == D_IACK ||
                         ((dec_q == D_ROM || dec_q == D_IO) && wait_cnt == '0))
                    state_nxt = S_ACK;
            end
            S_ACK:    if (as_s) state_nxt = S_TERM;
            S_TERM:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Counters and next values of the registered outputs
    always_comb begin
        dec_nxt        = dec_q;
        wait_nxt       = wait_cnt;
        tmo_nxt        = tmo_cnt;
        boot_nxt       = boot_cnt;
        dram_acked_nxt = dram_acked;
        ack0_nxt       = ack0_q;
        ack1_nxt       = ack1_q;
        cs_dram_nxt    = CS_DRAM_n;
        cs_rom_nxt     = CS_ROM_n;
        cs_io_nxt      = CS_IO_n;
        avec_nxt       = AVEC_n;
        berr_nxt       = BERR_n;
        case (state)
            S_DECODE: begin
                dec_nxt        = dec_c;
                tmo_nxt        = '0;
                dram_acked_nxt = 1'b0;
                wait_nxt       = (dec_c == D_IO) ? WAIT_W'(IO_LOAD) : WAIT_W'(ROM_LOAD);
                if (!as_s) begin
                    cs_dram_nxt = (dec_c != D_DRAM);
                    cs_rom_nxt  = (dec_c != D_ROM);
                    cs_io_nxt   = (dec_c != D_IO);
                end
            end
            S_WAIT: begin
                if (!as_s) begin
                    if (wait_cnt != '0) wait_nxt = wait_cnt - 1'b1;
                    // Any DRAM acknowledge freezes the watchdog for the rest of the cycle
                    if (dram_ack) begin
                        dram_acked_nxt = 1'b1;
                    end else if (!dram_acked && tmo_cnt != TMO_W'(TMO_LAST)) begin
                        tmo_nxt = tmo_cnt + 1'b1;
                        if (tmo_cnt == TMO_W'(TMO_LAST - 1)) berr_nxt = 1'b0;
                    end
                end
            end
            S_TERM: begin
                if (overlay) boot_nxt = boot_cnt + 1'b1;
            end
            default: ;
        endcase
        if (state_nxt == S_ACK && state != S_ACK) begin
            ack1_nxt = (dec_sel != D_ROM);
            ack0_nxt = (dec_sel != D_IO);
            avec_nxt = (dec_sel != D_IACK);
        end
        if (state_nxt == S_TERM) begin
            cs_dram_nxt = 1'b1;
            cs_rom_nxt  = 1'b1;
            cs_io_nxt   = 1'b1;
            ack0_nxt    = 1'b1;
            ack1_nxt    = 1'b1;
            avec_nxt    = 1'b1;
            berr_nxt    = 1'b1;
        end
    end

    // DRAM acknowledge reaches the CPU only while the DRAM is selected
    assign DSACK0_n = ack0_q & (DSACK0_DRAM_n | CS_DRAM_n);
    assign DSACK1_n = ack1_q & (DSACK1_DRAM_n | CS_DRAM_n);

endmodule
